gpio_irq: RTL

Per-pin edge-detect interrupt unit sitting directly downstream of the GPIO block's input debouncers, consuming the same debounced input vector the GPIO block exposes at its debounced-input register. It detects rising and/or falling edges per pin and latches them into sticky status bits. It raises a level interrupt to the Ibex fast-interrupt/IRQ line. It is register-mapped on the same simple device bus as the GPIO peripheral (req/we/be/addr/wdata, rvalid one cycle later).

---
 rtl/gpio_irq.sv | 114 +++++++++++
 1 files changed

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - per-pin rising/falling edge interrupt unit on the simple device bus
module gpio_irq #(
    parameter int unsigned GpiWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    input  logic [GpiWidth-1:0] gp_dbnc_i,
    output logic                irq_o
);

    localparam logic [11:0] RiseEnOff = 12'h000;
    localparam logic [11:0] FallEnOff = 12'h004;
    localparam logic [11:0] StatusOff = 12'h008;
    localparam logic [11:0] SetOff    = 12'h00C;

    logic [GpiWidth-1:0] rise_en_q, rise_en_d;
    logic [GpiWidth-1:0] fall_en_q, fall_en_d;
    logic [GpiWidth-1:0] status_q, status_d;
    logic [GpiWidth-1:0] prev_q;
    logic                primed_q;
    logic                rvalid_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                irq_q;

    logic [11:0]         offset;
    logic                wr_en;
    logic [GpiWidth-1:0] lane_mask;
    logic [GpiWidth-1:0] wr_bits;
    logic [GpiWidth-1:0] w1c_mask, w1s_mask;
    logic [GpiWidth-1:0] rise, fall;
    logic                unused_bus;

    assign offset     = device_addr_i[11:0];
    assign wr_en      = device_req_i & device_we_i;
    assign unused_bus = ^{device_addr_i[31:12], device_wdata_i, device_be_i};

    // Pin i lives in byte lane i/8, so only that lane's enable lets a write reach it.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < int'(GpiWidth); i++) begin
            lane_mask[i] = device_be_i[i/8];
        end
    end

    assign wr_bits = device_wdata_i[GpiWidth-1:0] & lane_mask;

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_mask  = '0;
        w1s_mask  = '0;
        if (wr_en) begin
            unique case (offset)
                RiseEnOff: rise_en_d = (rise_en_q & ~lane_mask) | wr_bits;
                FallEnOff: fall_en_d = (fall_en_q & ~lane_mask) | wr_bits;
                StatusOff: w1c_mask  = wr_bits;
                SetOff:    w1s_mask  = wr_bits;
                default:   ;
            endcase
        end
    end

    // The priming cycle only loads prev_q, so a pin already high at reset release never flags.
    assign rise = primed_q ? (gp_dbnc_i & ~prev_q & rise_en_q) : '0;
    assign fall = primed_q ? (~gp_dbnc_i & prev_q & fall_en_q) : '0;

    assign status_d = (status_q & ~w1c_mask) | rise | fall | w1s_mask;

    always_comb begin
        rdata_d = '0;
        if (device_req_i && !device_we_i) begin
            unique case (offset)
                RiseEnOff: rdata_d = 32'(rise_en_q);
                FallEnOff: rdata_d = 32'(fall_en_q);
                StatusOff: rdata_d = 32'(status_q);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            primed_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= gp_dbnc_i;
            primed_q  <= 1'b1;
            rvalid_q  <= device_req_i;
            rdata_q   <= rdata_d;
            irq_q     <= |status_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign irq_o           = irq_q;

endmodule
